// File: rtl/rom_dl_wrbuf_if.sv
// ROM download bus: hps_io ioctl side plus the ddram toggle write port.
interface rom_dl_wrbuf_if #(
   parameter int AW = 25
);
   logic          ioctl_download;
   logic          ioctl_wr;
   logic [AW-1:0] ioctl_addr;
   logic [15:0]   ioctl_data;
   logic          ioctl_wait;
   logic [AW-1:0] wr_addr;
   logic [15:0]   wr_data;
   logic          wr_req;
   logic          wr_ack;
   logic [AW-2:0] rom_words;
   logic          overflow;
   logic          dl_done;

   modport master (
      output ioctl_download, ioctl_wr,
      output ioctl_addr, ioctl_data,
      output wr_ack,
      input  ioctl_wait,
      input  wr_addr, wr_data, wr_req,
      input  rom_words, overflow, dl_done
   );

   modport slave (
      input  ioctl_download, ioctl_wr,
      input  ioctl_addr, ioctl_data,
      input  wr_ack,
      output ioctl_wait,
      output wr_addr, wr_data, wr_req,
      output rom_words, overflow, dl_done
   );
endinterface

// File: rtl/rom_dl_wrbuf.sv
// ROM download write buffer: ioctl words into a small FIFO,
// drained one at a time to the ddram toggle write port.
module rom_dl_wrbuf #(
   parameter int DEPTH_LOG2 = 3,
   parameter int AW         = 25
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   rom_dl_wrbuf_if.slave bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      FINISH
   } state_t;

   typedef logic [DEPTH_LOG2-1:0] ptr_t;
   typedef logic [AW-2:0]         wa_t;

   state_t        state;
   logic [CW-1:0] count;
   ptr_t          wptr;
   ptr_t          rptr;
   logic          dl_q;
   logic          pend_done;

   wa_t           mem_a [DEPTH];
   logic [15:0]   mem_d [DEPTH];

   logic          start;
   logic          fall;
   logic          full;
   logic          push;
   logic          pop;
   logic          ack_ok;
   wa_t           in_a;
   wa_t           in_w;
   logic [15:0]   in_d;
   ptr_t          wsel;
   ptr_t          rnxt;
   logic [CW-1:0] cnt_pop;
   wa_t           nxt_a;
   logic [15:0]   nxt_d;
   logic          addr_unused;

   assign start   = bus.ioctl_download & ~dl_q;
   assign fall    = ~bus.ioctl_download & dl_q;
   assign full    = count == CW'(DEPTH);
   assign push    = bus.ioctl_wr & (start | ~full);
   assign ack_ok  = bus.wr_req == bus.wr_ack;
   assign pop     = (state == WAIT) & ack_ok & ~start;
   assign in_a    = bus.ioctl_addr[AW-1:1];
   assign in_w    = in_a + wa_t'(1);
   assign in_d    = {bus.ioctl_data[7:0],
                     bus.ioctl_data[15:8]};
   assign wsel    = start ? '0 : wptr;
   assign rnxt    = rptr + ptr_t'(1);
   assign cnt_pop = count - CW'(1);

   // last entry popping while a new word lands: take it straight from the bus
   assign nxt_a = (cnt_pop == '0) ? in_a : mem_a[rnxt];
   assign nxt_d = (cnt_pop == '0) ? in_d : mem_d[rnxt];

   assign bus.ioctl_wait = count >= CW'(DEPTH - 1);
   assign addr_unused    = bus.ioctl_addr[0];

   always_ff @(posedge clk_sys) begin
      if (push) begin
         mem_a[wsel] <= in_a;
         mem_d[wsel] <= in_d;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         count         <= '0;
         wptr          <= '0;
         rptr          <= '0;
         dl_q          <= 1'b0;
         pend_done     <= 1'b0;
         bus.wr_req    <= 1'b0;
         bus.wr_addr   <= '0;
         bus.wr_data   <= '0;
         bus.rom_words <= '0;
         bus.overflow  <= 1'b0;
         bus.dl_done   <= 1'b0;
      end else begin
         dl_q        <= bus.ioctl_download;
         bus.dl_done <= 1'b0;
         if (fall) pend_done <= 1'b1;
         if (start) begin
            pend_done     <= 1'b0;
            count         <= CW'(push);
            wptr          <= push ? ptr_t'(1) : '0;
            rptr          <= '0;
            bus.rom_words <= push ? in_w : '0;
            bus.overflow  <= 1'b0;
            bus.wr_req    <= bus.wr_ack;
            state         <= IDLE;
         end else begin
            count <= count + CW'(push) - CW'(pop);
            if (push) wptr <= wptr + ptr_t'(1);
            if (pop) rptr <= rnxt;
            if (push && in_w > bus.rom_words)
               bus.rom_words <= in_w;
            if (bus.ioctl_wr && full)
               bus.overflow <= 1'b1;
            unique case (state)
               IDLE: begin
                  if (count != '0) begin
                     bus.wr_addr <= {mem_a[rptr], 1'b0};
                     bus.wr_data <= mem_d[rptr];
                     bus.wr_req  <= ~bus.wr_req;
                     state       <= WAIT;
                  end else if (!bus.ioctl_download && pend_done) begin
                     bus.dl_done <= 1'b1;
                     state       <= FINISH;
                  end
               end
               WAIT: begin
                  if (ack_ok) begin
                     if (cnt_pop != '0 || push) begin
                        bus.wr_addr <= {nxt_a, 1'b0};
                        bus.wr_data <= nxt_d;
                        bus.wr_req  <= ~bus.wr_req;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end
               FINISH: begin
                  pend_done <= 1'b0;
                  state     <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_rom_dl_wrbuf.sv
// Directed bench for rom_dl_wrbuf with a small toggle-handshake
// ddram responder that logs every issued write.
module tb_rom_dl_wrbuf;
   localparam int AW = 25;

   logic clk_sys = 1'b0;
   logic reset_n;

   always #5 clk_sys = ~clk_sys;

   rom_dl_wrbuf_if #(.AW(AW)) b ();

   rom_dl_wrbuf #(
      .DEPTH_LOG2(3),
      .AW(AW)
   ) dut (
      .clk_sys(clk_sys),
      .reset_n(reset_n),
      .bus(b.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;

   bit ack_en  = 1'b0;
   bit ack_go  = 1'b0;
   bit frc_en  = 1'b1;
   bit frc_val = 1'b0;
   int ack_dly = 0;
   int acnt    = 0;
   logic seen  = 1'b0;

   logic [AW-1:0] log_a[$];
   logic [15:0]   log_d[$];

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h",
                  tag, got, exp);
      end
   endtask

   // ddram side: acks after ack_dly cycles, logs each new request
   always @(posedge clk_sys) begin
      if (frc_en)
         b.wr_ack <= frc_val;
      else if (ack_go)
         b.wr_ack <= b.wr_req;
      else if (ack_en && b.wr_req != b.wr_ack) begin
         if (acnt >= ack_dly) begin
            b.wr_ack <= b.wr_req;
            acnt     <= 0;
         end else begin
            acnt <= acnt + 1;
         end
      end
      if (b.wr_req == b.wr_ack) begin
         seen <= b.wr_req;
         acnt <= 0;
      end else if (b.wr_req != seen) begin
         seen <= b.wr_req;
         log_a.push_back(b.wr_addr);
         log_d.push_back(b.wr_data);
      end
   end

   task automatic tick();
      @(negedge clk_sys);
   endtask

   task automatic dl_start();
      b.ioctl_download = 1'b0;
      tick();
      tick();
      b.ioctl_download = 1'b1;
      tick();
   endtask

   task automatic strobe(input logic [AW-1:0] a,
                         input logic [15:0] d);
      b.ioctl_wr   = 1'b1;
      b.ioctl_addr = a;
      b.ioctl_data = d;
      tick();
      b.ioctl_wr   = 1'b0;
   endtask

   task automatic drain(input string tag, input int lim);
      int n;
      n = 0;
      while ((b.wr_req != b.wr_ack || dut.count != '0)
             && n < lim) begin
         tick();
         n++;
      end
      chk(tag, 32'(n < lim), 1);
   endtask

   task automatic clr_log();
      log_a.delete();
      log_d.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic          r0;
      logic          r1;
      logic          saw;
      int            n;
      int            ndone;
      int            ntog;
      logic [7:0]    li;

      b.ioctl_download = 1'b0;
      b.ioctl_wr       = 1'b0;
      b.ioctl_addr     = '0;
      b.ioctl_data     = '0;
      reset_n          = 1'b0;
      repeat (2) tick();

      chk("rst_wait", b.ioctl_wait, 0);
      chk("rst_req", b.wr_req, 0);
      chk("rst_addr", b.wr_addr, 0);
      chk("rst_data", b.wr_data, 0);
      chk("rst_rom", b.rom_words, 0);
      chk("rst_ovf", b.overflow, 0);
      chk("rst_done", b.dl_done, 0);
      reset_n = 1'b1;
      frc_en  = 1'b0;
      tick();

      // single word, latency and completion pulse
      ack_en  = 1'b1;
      ack_dly = 5;
      dl_start();
      chk("t2_rom0", b.rom_words, 0);
      r0 = b.wr_req;
      r1 = ~r0;
      strobe(25'h000100, 16'h1234);
      chk("t2_lat1", b.wr_req, r0);
      tick();
      chk("t2_lat2", b.wr_req, r1);
      chk("t2_data", b.wr_data, 32'h3412);
      chk("t2_addr", b.wr_addr, 32'h100);
      chk("t2_rom", b.rom_words, 32'h81);
      chk("t2_done_early", b.dl_done, 0);
      drain("t2_drain", 40);
      b.ioctl_download = 1'b0;
      ndone = 0;
      repeat (10) begin
         tick();
         if (b.dl_done) ndone++;
      end
      chk("t2_done", ndone, 1);

      // 20 words, slow ddram, HPS honours ioctl_wait
      ack_dly = 10;
      dl_start();
      clr_log();
      saw = 1'b0;
      for (int i = 0; i < 20; i++) begin
         n = 0;
         while (b.ioctl_wait && n < 200) begin
            if (!saw) begin
               saw = 1'b1;
               chk("t3_wait_at", 32'(dut.count), 7);
            end
            tick();
            n++;
         end
         chk("t3_wait_to", 32'(n < 200), 1);
         strobe(25'(2 * i), 16'(32'hA000 + i));
      end
      drain("t3_drain", 600);
      chk("t3_saw_wait", saw, 1);
      chk("t3_ovf", b.overflow, 0);
      chk("t3_nwr", log_a.size(), 20);
      if (log_a.size() == 20) begin
         for (int i = 0; i < 20; i++) begin
            li = 8'(i);
            chk("t3_addr", log_a[i], 32'(2 * i));
            chk("t3_data", log_d[i], {16'h0, li, 8'hA0});
         end
      end

      // overflow: ddram stalled, bench ignores ioctl_wait
      ack_en = 1'b0;
      dl_start();
      clr_log();
      for (int i = 0; i < 9; i++)
         strobe(25'(32'h200 + 2 * i), 16'(32'hB000 + i));
      chk("t4_ovf", b.overflow, 1);
      chk("t4_wait", b.ioctl_wait, 1);
      chk("t4_cnt", 32'(dut.count), 8);
      chk("t4_rom", b.rom_words, 32'h108);
      ack_en  = 1'b1;
      ack_dly = 1;
      drain("t4_drain", 200);
      chk("t4_nwr", log_a.size(), 8);
      if (log_a.size() == 8) begin
         chk("t4_last_a", log_a[7], 32'h20E);
         chk("t4_last_d", log_d[7], 32'h07B0);
      end
      dl_start();
      chk("t4_ovf_clr", b.overflow, 0);
      chk("t4_rom_clr", b.rom_words, 0);

      // async reset while a request is outstanding
      ack_en = 1'b0;
      dl_start();
      for (int i = 0; i < 9; i++)
         strobe(25'(32'h400 + 2 * i), 16'(32'hC000 + i));
      chk("t1_pre_ovf", b.overflow, 1);
      chk("t1_pre_wait", b.ioctl_wait, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("t1_wait", b.ioctl_wait, 0);
      chk("t1_req", b.wr_req, 0);
      chk("t1_addr", b.wr_addr, 0);
      chk("t1_data", b.wr_data, 0);
      chk("t1_rom", b.rom_words, 0);
      chk("t1_ovf", b.overflow, 0);
      chk("t1_done", b.dl_done, 0);
      tick();
      reset_n = 1'b1;

      // push and ack in the same cycle with four entries
      dl_start();
      for (int i = 0; i < 4; i++)
         strobe(25'(32'h300 + 2 * i), 16'(32'h5500 + i));
      tick();
      chk("t5_cnt0", 32'(dut.count), 4);
      ack_go = 1'b1;
      tick();
      ack_go = 1'b0;
      r0 = b.wr_req;
      r1 = ~r0;
      strobe(25'h308, 16'h5504);
      chk("t5_cnt", 32'(dut.count), 4);
      chk("t5_tog", b.wr_req, r1);
      chk("t5_addr", b.wr_addr, 32'h302);
      chk("t5_data", b.wr_data, 32'h0155);
      ack_en  = 1'b1;
      ack_dly = 1;
      drain("t5_drain", 100);

      // toggle resync with wr_ack parked at 1
      b.ioctl_download = 1'b0;
      ack_en  = 1'b0;
      frc_val = 1'b1;
      frc_en  = 1'b1;
      repeat (3) tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("t6_rst_req", b.wr_req, 0);
      tick();
      b.ioctl_download = 1'b1;
      tick();
      chk("t6_sync_a", b.wr_req, 1);
      b.ioctl_download = 1'b0;
      repeat (4) tick();
      b.ioctl_download = 1'b1;
      tick();
      chk("t6_sync_b", b.wr_req, 1);
      frc_en  = 1'b0;
      ack_en  = 1'b1;
      ack_dly = 2;
      clr_log();
      ntog = 0;
      r0 = b.wr_req;
      b.ioctl_wr   = 1'b1;
      b.ioctl_addr = 25'h500;
      b.ioctl_data = 16'hBEEF;
      tick();
      b.ioctl_wr   = 1'b0;
      repeat (20) begin
         if (b.wr_req != r0) ntog++;
         r0 = b.wr_req;
         tick();
      end
      chk("t6_ntog", ntog, 1);
      chk("t6_nwr", log_a.size(), 1);
      if (log_a.size() == 1) begin
         chk("t6_addr", log_a[0], 32'h500);
         chk("t6_data", log_d[0], 32'hEFBE);
      end
      chk("t6_req_end", b.wr_req, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
